// File: rtl/juice_dispenser.sv
// juice_dispenser: turns request edges into timed pump pours or coin bursts, one request queued; outputs registered (action starts 1 cycle after edge).
// `CUP_SENSE_EN adds WAIT_CUP and a pour abort on cup removal; without it cup_present is ignored and cup_error is 0.
module juice_dispenser #(
    parameter int POUR_CYCLES  = 8,
    parameter int CHANGE_COINS = 4,
    parameter int COIN_PULSE   = 2,
    parameter int COIN_GAP     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic juice_1,
    input  logic juice_2,
    input  logic return_change,
    input  logic cup_present,
    output logic pump_1,
    output logic pump_2,
    output logic coin_out,
    output logic busy,
    output logic done,
    output logic overflow,
    output logic cup_error
);
    localparam int PH_A   = (POUR_CYCLES > COIN_PULSE) ? POUR_CYCLES : COIN_PULSE;
    localparam int PH_MAX = (PH_A > COIN_GAP) ? PH_A : COIN_GAP;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;
    localparam int CN_W   = (CHANGE_COINS > 1) ? $clog2(CHANGE_COINS + 1) : 1;

    localparam logic [PH_W-1:0] POUR_LD = PH_W'(POUR_CYCLES - 1);
    localparam logic [PH_W-1:0] HI_LD   = PH_W'(COIN_PULSE - 1);
    localparam logic [PH_W-1:0] LO_LD   = PH_W'(COIN_GAP - 1);
    localparam logic [CN_W-1:0] COIN_LD = CN_W'(CHANGE_COINS - 1);

    typedef enum logic [1:0] {K_P1 = 2'd0, K_P2 = 2'd1, K_CHG = 2'd2} kind_t;

    typedef enum logic [2:0] {
        S_IDLE, S_POUR, S_COIN_HI, S_COIN_LO, S_DONE
`ifdef CUP_SENSE_EN
        , S_WAIT_CUP
`endif
    } state_t;

    state_t          r_state;
    logic [PH_W-1:0] r_ph_cnt;
    logic [CN_W-1:0] r_coin_cnt;
    logic [2:0]      r_in_q;
    logic            r_pend_vld;
    kind_t           r_pend_kind;
    logic            r_pump_1, r_pump_2, r_coin_out, r_busy, r_done, r_overflow, r_cup_error;
`ifdef CUP_SENSE_EN
    kind_t           r_kind;
`else
    logic            w_unused_cup;
    assign w_unused_cup = cup_present;
`endif

    logic [2:0] w_req;
    logic       w_start_vld, w_pend_vld, w_drop;
    kind_t      w_start_kind, w_pend_kind;

    // bit order of w_req is the priority order: juice_1 first
    assign w_req = {return_change, juice_2, juice_1} & ~r_in_q;

    always_comb begin
        w_start_vld  = 1'b0;
        w_start_kind = r_pend_kind;
        w_pend_vld   = r_pend_vld;
        w_pend_kind  = r_pend_kind;
        w_drop       = 1'b0;
        if (r_state == S_IDLE && r_pend_vld) begin
            w_start_vld = 1'b1;
            w_pend_vld  = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (w_req[k]) begin
                if (r_state == S_IDLE && !w_start_vld) begin
                    w_start_vld  = 1'b1;
                    w_start_kind = kind_t'(k[1:0]);
                end else if (!w_pend_vld) begin
                    w_pend_vld  = 1'b1;
                    w_pend_kind = kind_t'(k[1:0]);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ph_cnt    <= '0;
            r_coin_cnt  <= '0;
            r_in_q      <= 3'b111;
            r_pend_vld  <= 1'b0;
            r_pend_kind <= K_P1;
            r_pump_1    <= 1'b0;
            r_pump_2    <= 1'b0;
            r_coin_out  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_cup_error <= 1'b0;
`ifdef CUP_SENSE_EN
            r_kind      <= K_P1;
`endif
        end else begin
            r_in_q      <= {return_change, juice_2, juice_1};
            r_pend_vld  <= w_pend_vld;
            r_pend_kind <= w_pend_kind;
            r_done      <= 1'b0;
            r_cup_error <= 1'b0;
            if (w_drop)
                r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_start_vld) begin
                        r_busy <= 1'b1;
                        if (w_start_kind == K_CHG) begin
                            r_state    <= S_COIN_HI;
                            r_ph_cnt   <= HI_LD;
                            r_coin_cnt <= COIN_LD;
                            r_coin_out <= 1'b1;
                        end else begin
`ifdef CUP_SENSE_EN
                            r_state <= S_WAIT_CUP;
                            r_kind  <= w_start_kind;
`else
                            r_state  <= S_POUR;
                            r_ph_cnt <= POUR_LD;
                            r_pump_1 <= (w_start_kind == K_P1);
                            r_pump_2 <= (w_start_kind == K_P2);
`endif
                        end
                    end
                end
`ifdef CUP_SENSE_EN
                S_WAIT_CUP: begin
                    if (cup_present) begin
                        r_state  <= S_POUR;
                        r_ph_cnt <= POUR_LD;
                        r_pump_1 <= (r_kind == K_P1);
                        r_pump_2 <= (r_kind == K_P2);
                    end
                end
`endif
                S_POUR: begin
`ifdef CUP_SENSE_EN
                    // cup removal wins over a normal finish in the same cycle
                    if (!cup_present) begin
                        r_state     <= S_DONE;
                        r_pump_1    <= 1'b0;
                        r_pump_2    <= 1'b0;
                        r_done      <= 1'b1;
                        r_cup_error <= 1'b1;
                    end else
`endif
                    if (r_ph_cnt == '0) begin
                        r_state  <= S_DONE;
                        r_pump_1 <= 1'b0;
                        r_pump_2 <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_ph_cnt <= r_ph_cnt - 1'b1;
                    end
                end
                S_COIN_HI: begin
                    if (r_ph_cnt != '0) begin
                        r_ph_cnt <= r_ph_cnt - 1'b1;
                    end else if (r_coin_cnt == '0) begin
                        r_state    <= S_DONE;
                        r_coin_out <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= S_COIN_LO;
                        r_ph_cnt   <= LO_LD;
                        r_coin_cnt <= r_coin_cnt - 1'b1;
                        r_coin_out <= 1'b0;
                    end
                end
                S_COIN_LO: begin
                    if (r_ph_cnt != '0) begin
                        r_ph_cnt <= r_ph_cnt - 1'b1;
                    end else begin
                        r_state    <= S_COIN_HI;
                        r_ph_cnt   <= HI_LD;
                        r_coin_out <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_pump_1   <= 1'b0;
                    r_pump_2   <= 1'b0;
                    r_coin_out <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign pump_1    = r_pump_1;
    assign pump_2    = r_pump_2;
    assign coin_out  = r_coin_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign cup_error = r_cup_error;
endmodule

// File: doc/juice_dispenser.md
# juice_dispenser

Actuator back-end for the juice vending controller. It consumes the controller's level outputs `juice_1`, `juice_2` and `return_change`, and turns each rising edge into a timed physical action:

- a pour on pump 1 or pump 2, or
- a burst of coin-release pulses.

It reports `busy` and a one-cycle `done`, and holds one request queued while an action is in progress.

## Interface

Parameters:
- `POUR_CYCLES`, default 8: cycles a pump output stays high per pour (≥1).
- `CHANGE_COINS`, default 4: coin pulses per change return (≥1).
- `COIN_PULSE`, default 2: high cycles per coin pulse (≥1).
- `COIN_GAP`, default 2: low cycles between coin pulses (≥1).

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `juice_1`, input, 1: pour request level for pump 1.
- `juice_2`, input, 1: pour request level for pump 2.
- `return_change`, input, 1: change request level.
- `cup_present`, input, 1: cup sensor. Used only with `CUP_SENSE_EN`; ignored otherwise.
- `pump_1`, output, 1: pump 1 drive.
- `pump_2`, output, 1: pump 2 drive.
- `coin_out`, output, 1: coin release solenoid.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when an action completes or aborts.
- `overflow`, output, 1: sticky; a request was dropped.
- `cup_error`, output, 1: one-cycle pulse on pour abort. Tied 0 without `CUP_SENSE_EN`.

## Operation

Edge detection and priority:
- Each request input is registered. A request is `in & ~in_q`.
- The `in_q` registers reset to 1. An input already high at reset release (e.g. `return_change` in the controller's idle state) does not trigger.
- When edges occur in the same cycle, priority is `juice_1` > `juice_2` > `return_change`.

Pending slot and overflow:
- There is one pending slot holding a request kind (P1, P2, CHG) and a valid bit.
- A request edge that is not started immediately goes to the pending slot if it is empty. Otherwise it is dropped and `overflow` is set.
- Losers of a same-cycle priority conflict follow the same rule. The highest-priority loser is queued; any others are dropped and set `overflow`.
- In IDLE, a valid pending entry starts before any new edge in that cycle. A new edge in that cycle then goes to the now-free pending slot.

State machine:
- **IDLE**: start the selected request.
  - Pour goes to POUR, or to WAIT_CUP with the macro.
  - Change goes to COIN_HI.
- **WAIT_CUP** (macro only): wait until `cup_present`=1, then go to POUR. No timeout.
- **POUR**: drive the selected pump for `POUR_CYCLES` cycles, then go to DONE.
- **COIN_HI**: `coin_out`=1 for `COIN_PULSE` cycles.
  - After the last coin, go to DONE.
  - Otherwise go to COIN_LO.
- **COIN_LO**: `coin_out`=0 for `COIN_GAP` cycles, then go to COIN_HI.
- **DONE**: `done`=1 for one cycle, then go to IDLE.

Counters and outputs:
- One phase counter, sized for the largest of `POUR_CYCLES`, `COIN_PULSE` and `COIN_GAP`.
- One coin counter, sized for `CHANGE_COINS`. Neither counter wraps; both reload on phase entry.
- Outputs are registered and decoded from state. At most one of `pump_1`, `pump_2`, `coin_out` is high in any cycle.

Reset:
- Reset values: all outputs 0, state IDLE, pending slot empty, `overflow` 0.
- Reset mid-action drops all outputs on assertion, with no `done` pulse.

## Timing

- Request edge sampled at edge N (input high, `in_q` low), FSM idle, no pending entry.
- Pour:
  - `pump_x` is high from cycle N+1 through N+`POUR_CYCLES`.
  - `done` is high in cycle N+`POUR_CYCLES`+1, and the FSM is in IDLE at N+`POUR_CYCLES`+2.
- Change:
  - `coin_out` high phases: `COIN_PULSE` cycles each, separated by `COIN_GAP` low cycles.
  - There is no trailing gap. `done` follows the last high cycle directly.
  - Total busy time is `CHANGE_COINS`×`COIN_PULSE` + (`CHANGE_COINS`−1)×`COIN_GAP` + 1 cycles.
- Back-to-back work: a pending request starts in the first IDLE cycle after DONE, and its action begins the cycle after that.

## Configuration

Macro: `CUP_SENSE_EN`.

When defined:
- WAIT_CUP is present.
- If `cup_present` falls during POUR, the pump drops the same cycle the low level is sampled.
- The FSM then goes to DONE, and `cup_error` pulses together with `done`.

When undefined:
- There is no WAIT_CUP state. `cup_present` is ignored and `cup_error` is constant 0.

## Test plan

- Reset release with `return_change`=1 held → no `coin_out` activity, `busy`=0 for 20 cycles.
- `juice_1` rises at edge 10, defaults → `pump_1` high cycles 11–18, `done` at cycle 19, `busy` low at 20.
- `return_change` rises, defaults → pattern 11 00 11 00 11 00 11 on `coin_out`, then `done`; 4 pulses counted.
- `juice_1` and `juice_2` rise in the same cycle, then `return_change` rises during the pour:
  - pump 1 pours first, then pump 2 from pending;
  - `return_change` is dropped and `overflow`=1.
- With `CUP_SENSE_EN`, `juice_2` rises with `cup_present`=0 → `pump_2` stays 0; `cup_present` goes to 1 → pour starts next cycle.
- With `CUP_SENSE_EN`, `cup_present` drops at pour cycle 3 → `pump_2` low, then `done`=`cup_error`=1 for one cycle.
